// File: rtl/mips_alu_pkg.sv
// Shared opcode, funct and decoded-operation definitions for the MIPS-I ALU datapath.
package mips_alu_pkg;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluRtype = 4'd1;
    localparam logic [3:0] AluBeq   = 4'd2;
    localparam logic [3:0] AluBne   = 4'd3;
    localparam logic [3:0] AluBlez  = 4'd4;
    localparam logic [3:0] AluBgtz  = 4'd5;
    localparam logic [3:0] AluBltz  = 4'd6;
    localparam logic [3:0] AluBgez  = 4'd7;
    localparam logic [3:0] AluSlti  = 4'd8;
    localparam logic [3:0] AluSltiu = 4'd9;
    localparam logic [3:0] AluAndi  = 4'd10;
    localparam logic [3:0] AluOri   = 4'd11;
    localparam logic [3:0] AluXori  = 4'd12;
    localparam logic [3:0] AluLui   = 4'd13;

    localparam logic [5:0] FunctSll   = 6'h00;
    localparam logic [5:0] FunctSrl   = 6'h02;
    localparam logic [5:0] FunctSra   = 6'h03;
    localparam logic [5:0] FunctSllv  = 6'h04;
    localparam logic [5:0] FunctSrlv  = 6'h06;
    localparam logic [5:0] FunctSrav  = 6'h07;
    localparam logic [5:0] FunctJr    = 6'h08;
    localparam logic [5:0] FunctJalr  = 6'h09;
    localparam logic [5:0] FunctMfhi  = 6'h10;
    localparam logic [5:0] FunctMthi  = 6'h11;
    localparam logic [5:0] FunctMflo  = 6'h12;
    localparam logic [5:0] FunctMtlo  = 6'h13;
    localparam logic [5:0] FunctMult  = 6'h18;
    localparam logic [5:0] FunctMultu = 6'h19;
    localparam logic [5:0] FunctDiv   = 6'h1A;
    localparam logic [5:0] FunctDivu  = 6'h1B;
    localparam logic [5:0] FunctAdd   = 6'h20;
    localparam logic [5:0] FunctAddu  = 6'h21;
    localparam logic [5:0] FunctSub   = 6'h22;
    localparam logic [5:0] FunctSubu  = 6'h23;
    localparam logic [5:0] FunctAnd   = 6'h24;
    localparam logic [5:0] FunctOr    = 6'h25;
    localparam logic [5:0] FunctXor   = 6'h26;
    localparam logic [5:0] FunctNor   = 6'h27;
    localparam logic [5:0] FunctSlt   = 6'h2A;
    localparam logic [5:0] FunctSltu  = 6'h2B;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSltu,
        OpSll, OpSrl, OpSra, OpLui, OpMfhi, OpMflo
    } alu_func_t;

    typedef enum logic [2:0] {
        MdNone, MdMult, MdMultu, MdDiv, MdDivu, MdMthi, MdMtlo
    } muldiv_op_t;

endpackage

// File: rtl/mips_alu_datapath_if.sv
// Operand/control inputs and result outputs of the ALU datapath.
interface mips_alu_datapath_if;
    logic [3:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        muldiv_write;
    logic [31:0] result;
    logic        condition;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output aluop, funct, a, b, shamt, muldiv_write,
        input  result, condition, hi, lo
    );

    modport slave (
        input  aluop, funct, a, b, shamt, muldiv_write,
        output result, condition, hi, lo
    );
endinterface

// File: rtl/mips_alu_muldiv_regs.sv
// HI/LO registers with single-cycle multiply/divide and MTHI/MTLO writes.
module mips_alu_muldiv_regs
    import mips_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  muldiv_op_t  op,
    input  logic        write,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_q, lo_q, hi_d, lo_d;
    logic [63:0] prod;
    logic        div_signed;
    logic [31:0] num, den, quo_mag, rem_mag, quo, rem;

    // Signed divide runs on magnitudes so -2^31 / -1 has a defined wrapped result.
    always_comb begin
        div_signed = (op == MdDiv);
        num        = (div_signed && a[31]) ? -a : a;
        den        = (div_signed && b[31]) ? -b : b;
        quo_mag    = (den != 32'd0) ? num / den : 32'd0;
        rem_mag    = (den != 32'd0) ? num % den : 32'd0;
        quo        = (div_signed && (a[31] ^ b[31])) ? -quo_mag : quo_mag;
        rem        = (div_signed && a[31]) ? -rem_mag : rem_mag;
    end

    always_comb begin
        if (op == MdMult) begin
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (write) begin
            case (op)
                MdMult, MdMultu: begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                MdDiv, MdDivu: begin
                    if (b != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
                MdMthi:  hi_d = a;
                MdMtlo:  lo_d = a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mips_alu_datapath.sv
// Combinational MIPS-I ALU with opcode/funct decode, branch condition and HI/LO unit.
module mips_alu_datapath
    import mips_alu_pkg::*;
(
    input logic                clk,
    input logic                reset,
    mips_alu_datapath_if.slave bus
);

    alu_func_t   func;
    muldiv_op_t  md_op;
    logic [4:0]  sh;
    logic [31:0] hi, lo;

    always_comb begin
        func  = OpAdd;
        md_op = MdNone;
        sh    = bus.shamt;
        case (bus.aluop)
            AluRtype: begin
                case (bus.funct)
                    FunctSub, FunctSubu: func = OpSub;
                    FunctAnd:            func = OpAnd;
                    FunctOr:             func = OpOr;
                    FunctXor:            func = OpXor;
                    FunctNor:            func = OpNor;
                    FunctSlt:            func = OpSlt;
                    FunctSltu:           func = OpSltu;
                    FunctSll:            func = OpSll;
                    FunctSrl:            func = OpSrl;
                    FunctSra:            func = OpSra;
                    FunctSllv: begin func = OpSll; sh = bus.a[4:0]; end
                    FunctSrlv: begin func = OpSrl; sh = bus.a[4:0]; end
                    FunctSrav: begin func = OpSra; sh = bus.a[4:0]; end
                    FunctMfhi:           func = OpMfhi;
                    FunctMflo:           func = OpMflo;
                    default:             func = OpAdd;
                endcase
                case (bus.funct)
                    FunctMult:  md_op = MdMult;
                    FunctMultu: md_op = MdMultu;
                    FunctDiv:   md_op = MdDiv;
                    FunctDivu:  md_op = MdDivu;
                    FunctMthi:  md_op = MdMthi;
                    FunctMtlo:  md_op = MdMtlo;
                    default:    md_op = MdNone;
                endcase
            end
            AluBeq, AluBne, AluBlez, AluBgtz, AluBltz, AluBgez: func = OpSub;
            AluSlti:  func = OpSlt;
            AluSltiu: func = OpSltu;
            AluAndi:  func = OpAnd;
            AluOri:   func = OpOr;
            AluXori:  func = OpXor;
            AluLui:   func = OpLui;
            default:  func = OpAdd;
        endcase
    end

    always_comb begin
        unique case (func)
            OpAdd:  bus.result = bus.a + bus.b;
            OpSub:  bus.result = bus.a - bus.b;
            OpAnd:  bus.result = bus.a & bus.b;
            OpOr:   bus.result = bus.a | bus.b;
            OpXor:  bus.result = bus.a ^ bus.b;
            OpNor:  bus.result = ~(bus.a | bus.b);
            OpSlt:  bus.result = {31'd0, $signed(bus.a) < $signed(bus.b)};
            OpSltu: bus.result = {31'd0, bus.a < bus.b};
            OpSll:  bus.result = bus.b << sh;
            OpSrl:  bus.result = bus.b >> sh;
            OpSra:  bus.result = $signed(bus.b) >>> sh;
            OpLui:  bus.result = {bus.b[15:0], 16'h0000};
            OpMfhi: bus.result = hi;
            OpMflo: bus.result = lo;
            default: bus.result = bus.a + bus.b;
        endcase
    end

    always_comb begin
        case (bus.aluop)
            AluBeq:  bus.condition = (bus.a == bus.b);
            AluBne:  bus.condition = (bus.a != bus.b);
            AluBlez: bus.condition = bus.a[31] || (bus.a == 32'd0);
            AluBgtz: bus.condition = !bus.a[31] && (bus.a != 32'd0);
            AluBltz: bus.condition = bus.a[31];
            AluBgez: bus.condition = !bus.a[31];
            default: bus.condition = 1'b0;
        endcase
    end

    mips_alu_muldiv_regs u_muldiv (
        .clk   (clk),
        .reset (reset),
        .op    (md_op),
        .write (bus.muldiv_write),
        .a     (bus.a),
        .b     (bus.b),
        .hi    (hi),
        .lo    (lo)
    );

    assign bus.hi = hi;
    assign bus.lo = lo;

endmodule

// File: tb/tb_mips_alu_datapath.sv
// Self-checking bench: directed vector table, HI/LO sequences and randomized model compare.
module tb_mips_alu_datapath;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    mips_alu_datapath_if bus ();

    mips_alu_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [31:0] res;
        logic        cond;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] m_hi, m_lo;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sa,
                                input logic [31:0] res, input logic cond);
        vec_t v;
        v.aluop = op; v.funct = fn; v.a = a; v.b = b; v.shamt = sa; v.res = res; v.cond = cond;
        return v;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sa, input logic wr);
        bus.aluop = op; bus.funct = fn; bus.a = a; bus.b = b; bus.shamt = sa;
        bus.muldiv_write = wr;
    endtask

    // Apply at the falling edge so the write lands on the next rising edge, then sample.
    task automatic md_cycle(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                            input logic wr, input logic rst);
        @(negedge clk);
        drive(4'd1, fn, a, b, 5'd0, wr);
        reset = rst;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [5:0] fn,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [4:0] sa, input logic [31:0] hi,
                                               input logic [31:0] lo);
        int sa_i, sb_i;
        int unsigned amt;
        sa_i = int'(a);
        sb_i = int'(b);
        amt  = 32'(sa);
        if (op >= 4'd2 && op <= 4'd7) return a - b;
        if (op == 4'd8) return (sa_i < sb_i) ? 32'd1 : 32'd0;
        if (op == 4'd9) return (a < b) ? 32'd1 : 32'd0;
        if (op == 4'd10) return a & b;
        if (op == 4'd11) return a | b;
        if (op == 4'd12) return a ^ b;
        if (op == 4'd13) return b * 32'h10000;
        if (op != 4'd1) return a + b;
        if (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) amt = 32'(a[4:0]);
        case (fn)
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (sa_i < sb_i) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h00, 6'h04: return 32'(64'(b) * (64'd1 << amt));
            6'h02, 6'h06: return 32'(64'(b) / (64'd1 << amt));
            6'h03, 6'h07: return 32'(sb_i >>> amt);
            6'h10: return hi;
            6'h12: return lo;
            default: return a + b;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        int s;
        s = int'(a);
        case (op)
            4'd2: return a == b;
            4'd3: return a != b;
            4'd4: return s <= 0;
            4'd5: return s > 0;
            4'd6: return s < 0;
            4'd7: return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic ref_muldiv(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sx, sy, q, r;
        longint unsigned p;
        sx = longint'(int'(a));
        sy = longint'(int'(b));
        case (fn)
            6'h18: begin p = longint'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
            6'h19: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
            6'h1A: if (b != 0) begin
                q = sx / sy; r = sx % sy; m_hi = 32'(r); m_lo = 32'(q);
            end
            6'h1B: if (b != 0) begin m_hi = a % b; m_lo = a / b; end
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0]  fn_list[20];
        logic [3:0]  op;
        logic [5:0]  fn;
        logic [31:0] ra, rb;
        logic [4:0]  rs;
        logic        wr;
        logic [31:0] exp_res;
        logic        exp_cond;
        bit          timed_out;

        fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h07, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h3F};

        vecs.push_back(mk(4'd1, 6'h21, 32'hFFFFFFFF, 32'd2, 5'd0, 32'h00000001, 1'b0));
        vecs.push_back(mk(4'd1, 6'h2A, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h00000001, 1'b0));
        vecs.push_back(mk(4'd1, 6'h2B, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h00000000, 1'b0));
        vecs.push_back(mk(4'd1, 6'h03, 32'd0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0));
        vecs.push_back(mk(4'd1, 6'h06, 32'h24, 32'h80000000, 5'd0, 32'h08000000, 1'b0));
        vecs.push_back(mk(4'd13, 6'h00, 32'd0, 32'h1234, 5'd0, 32'h12340000, 1'b0));
        vecs.push_back(mk(4'd2, 6'h00, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1));
        vecs.push_back(mk(4'd3, 6'h00, 32'd5, 32'd5, 5'd0, 32'h0, 1'b0));
        vecs.push_back(mk(4'd4, 6'h00, 32'd0, 32'd0, 5'd0, 32'h0, 1'b1));
        vecs.push_back(mk(4'd5, 6'h00, 32'd0, 32'd0, 5'd0, 32'h0, 1'b0));
        vecs.push_back(mk(4'd6, 6'h00, 32'h80000000, 32'd0, 5'd0, 32'h80000000, 1'b1));
        vecs.push_back(mk(4'd7, 6'h00, 32'd0, 32'd0, 5'd0, 32'h0, 1'b1));
        vecs.push_back(mk(4'd0, 6'h00, 32'd7, 32'd8, 5'd0, 32'h0000000F, 1'b0));
        vecs.push_back(mk(4'd1, 6'h27, 32'h0F0F0000, 32'h000000F0, 5'd0, 32'hF0F0FF0F, 1'b0));
        vecs.push_back(mk(4'd8, 6'h00, 32'hFFFFFFFF, 32'd0, 5'd0, 32'h1, 1'b0));
        vecs.push_back(mk(4'd9, 6'h00, 32'hFFFFFFFF, 32'd0, 5'd0, 32'h0, 1'b0));
        vecs.push_back(mk(4'd14, 6'h00, 32'd1, 32'd2, 5'd0, 32'h3, 1'b0));
        vecs.push_back(mk(4'd1, 6'h3F, 32'd1, 32'd1, 5'd0, 32'h2, 1'b0));
        vecs.push_back(mk(4'd1, 6'h23, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 1'b0));

        reset = 1'b1;
        drive(4'd0, 6'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].shamt, 1'b0);
            #1;
            check32($sformatf("vec%0d_result", i), bus.result, vecs[i].res);
            check1($sformatf("vec%0d_cond", i), bus.condition, vecs[i].cond);
        end

        md_cycle(6'h18, 32'hFFFFFFFD, 32'd7, 1'b1, 1'b0);
        check32("mult_hi", bus.hi, 32'hFFFFFFFF);
        check32("mult_lo", bus.lo, 32'hFFFFFFEB);
        md_cycle(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        check32("multu_hi", bus.hi, 32'hFFFFFFFE);
        check32("multu_lo", bus.lo, 32'h00000001);
        @(negedge clk);
        drive(4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        check32("mfhi_result", bus.result, 32'hFFFFFFFE);
        md_cycle(6'h1A, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        check32("div_hi", bus.hi, 32'hFFFFFFFF);
        check32("div_lo", bus.lo, 32'hFFFFFFFD);
        md_cycle(6'h1B, 32'd7, 32'd2, 1'b1, 1'b0);
        check32("divu_hi", bus.hi, 32'd1);
        check32("divu_lo", bus.lo, 32'd3);
        md_cycle(6'h1A, 32'd9, 32'd0, 1'b1, 1'b0);
        check32("div0_hi", bus.hi, 32'd1);
        check32("div0_lo", bus.lo, 32'd3);
        md_cycle(6'h11, 32'hAA, 32'd0, 1'b1, 1'b0);
        check32("mthi_hi", bus.hi, 32'hAA);
        check32("mthi_lo", bus.lo, 32'd3);
        md_cycle(6'h18, 32'd5, 32'd6, 1'b0, 1'b0);
        check32("nowrite_hi", bus.hi, 32'hAA);
        check32("nowrite_lo", bus.lo, 32'd3);
        md_cycle(6'h18, 32'd5, 32'd6, 1'b1, 1'b1);
        check32("rst_mult_hi", bus.hi, 32'd0);
        check32("rst_mult_lo", bus.lo, 32'd0);
        md_cycle(6'h13, 32'h55, 32'd0, 1'b1, 1'b0);
        check32("mtlo_hi", bus.hi, 32'd0);
        check32("mtlo_lo", bus.lo, 32'h55);
        @(negedge clk);
        drive(4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        check32("mflo_result", bus.result, 32'h55);

        m_hi = 32'd0;
        m_lo = 32'h55;
        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom_range(0, 15));
            fn = fn_list[$urandom_range(0, 19)];
            if (n % 5 == 0) begin
                op = 4'd1;
                fn = ($urandom_range(0, 1) == 0) ? 6'h19 : 6'h1B;
            end
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            rs = 5'($urandom);
            wr = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            drive(op, fn, ra, rb, rs, wr);
            #1;
            exp_res  = ref_result(op, fn, ra, rb, rs, m_hi, m_lo);
            exp_cond = ref_cond(op, ra, rb);
            check32($sformatf("rnd%0d_result op=%0d fn=%h", n, op, fn), bus.result, exp_res);
            check1($sformatf("rnd%0d_cond op=%0d", n, op), bus.condition, exp_cond);
            if (wr && op == 4'd1) ref_muldiv(fn, ra, rb);
            @(posedge clk);
            #1;
            check32($sformatf("rnd%0d_hi fn=%h", n, fn), bus.hi, m_hi);
            check32($sformatf("rnd%0d_lo fn=%h", n, fn), bus.lo, m_lo);
        end

        timed_out = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
